// File: rtl/axi_lite_arbiter.sv
// N-to-1 AXI-lite arbiter: independent round-robin write (AW/W/B) and read (AR/R) groups,
// one outstanding transaction per group, grant locked until the response handshake.
module axi_lite_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic                  aclk,
  input  logic                  arst,
  // Requester-side write address / data / response
  input  logic [N-1:0][63:0]    s_awaddr,
  input  logic [N-1:0][3:0]     s_awid,
  input  logic [N-1:0][2:0]     s_awprot,
  input  logic [N-1:0]          s_awvalid,
  input  logic [N-1:0][63:0]    s_wdata,
  input  logic [N-1:0][7:0]     s_wstrb,
  input  logic [N-1:0]          s_wvalid,
  input  logic [N-1:0]          s_bready,
  // Requester-side read address / data
  input  logic [N-1:0]          s_arvalid,
  input  logic [N-1:0]          s_rready,
  input  logic [N-1:0][63:0]    s_araddr,
  input  logic [N-1:0][3:0]     s_arid,
  input  logic [N-1:0][2:0]     s_arprot,
  output logic [N-1:0]          s_awready,
  output logic [N-1:0]          s_wready,
  output logic [N-1:0]          s_bvalid,
  output logic [N-1:0]          s_bresp,
  output logic [N-1:0]          s_arready,
  output logic [N-1:0]          s_rvalid,
  output logic [N-1:0]          s_rresp,
  output logic [N-1:0][63:0]    s_rdata,
  output logic [N-1:0][3:0]     s_rid,
  // Target-side ports
  output logic [63:0]           m_awaddr,
  output logic [3:0]            m_awid,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  output logic [63:0]           m_wdata,
  output logic [7:0]            m_wstrb,
  output logic                  m_wvalid,
  output logic                  m_bready,
  output logic                  m_arvalid,
  output logic                  m_rready,
  output logic [63:0]           m_araddr,
  output logic [3:0]            m_arid,
  output logic [2:0]            m_arprot,
  input  logic                  m_awready,
  input  logic                  m_wready,
  input  logic                  m_bvalid,
  input  logic                  m_bresp,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic                  m_rresp,
  input  logic [3:0]            m_rid,
  input  logic [63:0]           m_rdata
);

  localparam int unsigned GW = $clog2(N);

  typedef enum logic [1:0] {WIdle, WAddr, WResp} wstate_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} rstate_e;

  wstate_e        wstate;
  rstate_e        rstate;
  logic [GW-1:0]  wgnt, wlast, rgnt, rlast;
  logic           aw_done, w_done;
  logic           aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // First requester at or after last+1 (mod N); the last winner is checked last.
  function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] req, input logic [GW-1:0] last);
    logic [GW-1:0] pick;
    logic          found;
    int unsigned   idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = (32'(last) + off) % N;
      if (!found && req[idx[GW-1:0]]) begin
        pick  = idx[GW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;
  assign b_hs  = m_bvalid & m_bready;
  assign ar_hs = m_arvalid & m_arready;
  assign r_hs  = m_rvalid & m_rready;

  // Write group state
  always_ff @(posedge aclk) begin
    if (arst) begin
      wstate  <= WIdle;
      wgnt    <= '0;
      wlast   <= GW'(N - 1);
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (wstate)
        WIdle: begin
          if (|s_awvalid) begin
            wgnt   <= rr_pick(s_awvalid, wlast);
            wstate <= WAddr;
          end
        end
        WAddr: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) && (w_done | w_hs)) wstate <= WResp;
        end
        WResp: begin
          if (b_hs) begin
            wlast   <= wgnt;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wstate  <= WIdle;
          end
        end
        default: wstate <= WIdle;
      endcase
    end
  end

  // Read group state
  always_ff @(posedge aclk) begin
    if (arst) begin
      rstate <= RIdle;
      rgnt   <= '0;
      rlast  <= GW'(N - 1);
    end else begin
      case (rstate)
        RIdle: begin
          if (|s_arvalid) begin
            rgnt   <= rr_pick(s_arvalid, rlast);
            rstate <= RAddr;
          end
        end
        RAddr: begin
          if (ar_hs) rstate <= RData;
        end
        RData: begin
          if (r_hs) begin
            rlast  <= rgnt;
            rstate <= RIdle;
          end
        end
        default: rstate <= RIdle;
      endcase
    end
  end

  // Write routing: payload always follows the grant; only handshakes are state-qualified.
  always_comb begin
    m_awaddr  = s_awaddr[wgnt];
    m_awid    = s_awid[wgnt];
    m_awprot  = s_awprot[wgnt];
    m_wdata   = s_wdata[wgnt];
    m_wstrb   = s_wstrb[wgnt];
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = '0;
    case (wstate)
      WAddr: begin
        m_awvalid       = s_awvalid[wgnt] & ~aw_done;
        m_wvalid        = s_wvalid[wgnt] & ~w_done;
        s_awready[wgnt] = m_awready & ~aw_done;
        s_wready[wgnt]  = m_wready & ~w_done;
      end
      WResp: begin
        m_bready       = s_bready[wgnt];
        s_bvalid[wgnt] = m_bvalid;
        s_bresp[wgnt]  = m_bresp;
      end
      default: ;
    endcase
  end

  // Read routing; rdata/rid are broadcast, rvalid/rresp go to the grant only.
  always_comb begin
    m_araddr  = s_araddr[rgnt];
    m_arid    = s_arid[rgnt];
    m_arprot  = s_arprot[rgnt];
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_arready = '0;
    s_rvalid  = '0;
    s_rresp   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      s_rdata[i] = m_rdata;
      s_rid[i]   = m_rid;
    end
    case (rstate)
      RAddr: begin
        m_arvalid       = s_arvalid[rgnt];
        s_arready[rgnt] = m_arready;
      end
      RData: begin
        m_rready       = s_rready[rgnt];
        s_rvalid[rgnt] = m_rvalid;
        s_rresp[rgnt]  = m_rresp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench for axi_lite_arbiter (N=2): directed requester BFMs, a reactive slave model
// and a negedge monitor that pops expected transactions on every handshake.
module tb_axi_lite_arbiter;
  localparam int N = 2;

  logic aclk = 1'b0;
  logic arst;
  logic [N-1:0][63:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [N-1:0][3:0]  s_awid, s_arid, s_rid;
  logic [N-1:0][2:0]  s_awprot, s_arprot;
  logic [N-1:0][7:0]  s_wstrb;
  logic [N-1:0] s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [N-1:0] s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp;
  logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_awid, m_arid, m_rid;
  logic [2:0]  m_awprot, m_arprot;
  logic [7:0]  m_wstrb;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rresp;
  logic slv_bresp, slv_rresp;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [63:0] addr; logic [3:0] id; logic [2:0] prot; } ax_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; } w_t;
  typedef struct { int idx; logic resp; } b_t;
  typedef struct { int idx; logic [63:0] data; logic [3:0] id; logic resp; } r_t;
  ax_t aw_q[$];
  ax_t ar_q[$];
  w_t  w_q[$];
  b_t  b_q[$];
  r_t  r_q[$];

  always #5 aclk = ~aclk;

  axi_lite_arbiter #(.N(N)) dut (
    .aclk(aclk), .arst(arst),
    .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awprot(s_awprot), .s_awvalid(s_awvalid),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_rready(s_rready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arprot(s_arprot), .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid),
    .s_bresp(s_bresp), .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rresp(s_rresp),
    .s_rdata(s_rdata), .s_rid(s_rid),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awprot(m_awprot), .m_awvalid(m_awvalid),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_rready(m_rready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arprot(m_arprot), .m_awready(m_awready), .m_wready(m_wready), .m_bvalid(m_bvalid),
    .m_bresp(m_bresp), .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rresp(m_rresp),
    .m_rid(m_rid), .m_rdata(m_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: handshake seen, expected none pending", name);
  endtask

  task automatic push_wr(input int i, input logic [63:0] a, input logic [3:0] id,
                         input logic [63:0] d, input logic [7:0] st, input logic resp);
    aw_q.push_back('{addr: a, id: id, prot: 3'(i + 2)});
    w_q.push_back('{data: d, strb: st});
    b_q.push_back('{idx: i, resp: resp});
  endtask

  task automatic push_rd(input int i, input logic [63:0] a, input logic [3:0] id,
                         input logic [63:0] d, input logic resp);
    ar_q.push_back('{addr: a, id: id, prot: 3'(i + 2)});
    r_q.push_back('{idx: i, data: d, id: id, resp: resp});
  endtask

  // Requester write BFM: hold AW/W until each handshakes, then wait for B.
  task automatic wr(input int i, input logic [63:0] a, input logic [3:0] id,
                    input logic [63:0] d, input logic [7:0] st);
    logic awh, wh, done;
    int t;
    s_awaddr[i] = a; s_awid[i] = id; s_awprot[i] = 3'(i + 2);
    s_wdata[i] = d; s_wstrb[i] = st;
    s_awvalid[i] = 1'b1; s_wvalid[i] = 1'b1;
    done = 1'b0; t = 0;
    while (!done && t < 100) begin
      @(negedge aclk);
      awh = s_awvalid[i] & s_awready[i];
      wh = s_wvalid[i] & s_wready[i];
      done = s_bvalid[i] & s_bready[i];
      @(posedge aclk); #1;
      if (awh) s_awvalid[i] = 1'b0;
      if (wh) s_wvalid[i] = 1'b0;
      t++;
    end
    chk("wr_complete", 64'(done), 64'd1);
  endtask

  task automatic rd(input int i, input logic [63:0] a, input logic [3:0] id);
    logic arh, done;
    int t;
    s_araddr[i] = a; s_arid[i] = id; s_arprot[i] = 3'(i + 2);
    s_arvalid[i] = 1'b1;
    done = 1'b0; t = 0;
    while (!done && t < 100) begin
      @(negedge aclk);
      arh = s_arvalid[i] & s_arready[i];
      done = s_rvalid[i] & s_rready[i];
      @(posedge aclk); #1;
      if (arh) s_arvalid[i] = 1'b0;
      t++;
    end
    chk("rd_complete", 64'(done), 64'd1);
  endtask

  // Slave: B one cycle after both AW and W accepted; R one cycle after AR, rdata = araddr+0x1214.
  initial begin : slave
    logic awh, wh, bh, arh, rh, rst_seen, got_aw, got_w;
    logic [63:0] la;
    logic [3:0] li;
    got_aw = 1'b0; got_w = 1'b0; la = '0; li = '0;
    m_bvalid = 1'b0; m_bresp = 1'b0; m_rvalid = 1'b0; m_rresp = 1'b0;
    m_rdata = '0; m_rid = '0;
    forever begin
      @(negedge aclk);
      awh = m_awvalid & m_awready;
      wh = m_wvalid & m_wready;
      bh = m_bvalid & m_bready;
      arh = m_arvalid & m_arready;
      rh = m_rvalid & m_rready;
      rst_seen = arst;
      if (arh) begin la = m_araddr; li = m_arid; end
      @(posedge aclk); #1;
      if (rst_seen) begin
        got_aw = 1'b0; got_w = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
      end else begin
        if (awh) got_aw = 1'b1;
        if (wh) got_w = 1'b1;
        if (bh) m_bvalid = 1'b0;
        else if (got_aw && got_w && !m_bvalid) begin
          m_bvalid = 1'b1; m_bresp = slv_bresp; got_aw = 1'b0; got_w = 1'b0;
        end
        if (rh) m_rvalid = 1'b0;
        else if (arh) begin
          m_rvalid = 1'b1; m_rdata = la + 64'h1214; m_rid = li; m_rresp = slv_rresp;
        end
      end
    end
  end

  // Monitor: compare every handshake against the head of its queue.
  initial begin : monitor
    ax_t ea;
    w_t ew;
    b_t eb;
    r_t er;
    logic [N-1:0] oh;
    forever begin
      @(negedge aclk);
      if (m_awvalid && m_awready) begin
        if (aw_q.size() == 0) unexpected("aw_unexpected");
        else begin
          ea = aw_q.pop_front();
          chk("aw_addr", m_awaddr, ea.addr);
          chk("aw_id", 64'(m_awid), 64'(ea.id));
          chk("aw_prot", 64'(m_awprot), 64'(ea.prot));
        end
      end
      if (m_wvalid && m_wready) begin
        if (w_q.size() == 0) unexpected("w_unexpected");
        else begin
          ew = w_q.pop_front();
          chk("w_data", m_wdata, ew.data);
          chk("w_strb", 64'(m_wstrb), 64'(ew.strb));
        end
      end
      if (m_arvalid && m_arready) begin
        if (ar_q.size() == 0) unexpected("ar_unexpected");
        else begin
          ea = ar_q.pop_front();
          chk("ar_addr", m_araddr, ea.addr);
          chk("ar_id", 64'(m_arid), 64'(ea.id));
          chk("ar_prot", 64'(m_arprot), 64'(ea.prot));
        end
      end
      if ((s_bvalid & s_bready) != '0) begin
        if (b_q.size() == 0) unexpected("b_unexpected");
        else begin
          eb = b_q.pop_front();
          oh = '0; oh[eb.idx] = 1'b1;
          chk("b_valid_route", 64'(s_bvalid), 64'(oh));
          oh[eb.idx] = eb.resp;
          chk("b_resp", 64'(s_bresp), 64'(oh));
        end
      end
      if ((s_rvalid & s_rready) != '0) begin
        if (r_q.size() == 0) unexpected("r_unexpected");
        else begin
          er = r_q.pop_front();
          oh = '0; oh[er.idx] = 1'b1;
          chk("r_valid_route", 64'(s_rvalid), 64'(oh));
          chk("r_data", s_rdata[er.idx], er.data);
          chk("r_id", 64'(s_rid[er.idx]), 64'(er.id));
          oh[er.idx] = er.resp;
          chk("r_resp", 64'(s_rresp), 64'(oh));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run still active, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    arst = 1'b1;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; s_awid = '0; s_arid = '0;
    s_awprot = '0; s_arprot = '0; s_wstrb = '0;
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; s_bready = '1; s_rready = '1;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    slv_bresp = 1'b0; slv_rresp = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_outputs", 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 64'd0);
    chk("rst_m_outputs", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
    @(posedge aclk); #1;
    arst = 1'b0;

    // Single write from requester 0; AW appears one cycle after request
    @(posedge aclk); #1;
    push_wr(0, 64'h1000, 4'h0, 64'hDEADBEEF_00000001, 8'hFF, 1'b0);
    fork
      wr(0, 64'h1000, 4'h0, 64'hDEADBEEF_00000001, 8'hFF);
      begin
        @(negedge aclk); chk("t1_awvalid_arb_cycle", 64'(m_awvalid), 64'd0);
        @(negedge aclk); chk("t1_awvalid_next", 64'(m_awvalid), 64'd1);
      end
    join

    // Requester 1 alone, error response; leaves wlast=1
    slv_bresp = 1'b1;
    push_wr(1, 64'h1100, 4'h1, 64'h1111_2222_3333_4444, 8'h0F, 1'b1);
    wr(1, 64'h1100, 4'h1, 64'h1111_2222_3333_4444, 8'h0F);
    slv_bresp = 1'b0;

    // Contention: expected grant order 0,1,0,1
    push_wr(0, 64'h2000, 4'h2, 64'hA0, 8'h01, 1'b0);
    push_wr(1, 64'h2100, 4'h3, 64'hB0, 8'h02, 1'b0);
    push_wr(0, 64'h2008, 4'h4, 64'hA1, 8'h04, 1'b0);
    push_wr(1, 64'h2108, 4'h5, 64'hB1, 8'h08, 1'b0);
    fork
      begin
        wr(0, 64'h2000, 4'h2, 64'hA0, 8'h01);
        wr(0, 64'h2008, 4'h4, 64'hA1, 8'h04);
      end
      begin
        wr(1, 64'h2100, 4'h3, 64'hB0, 8'h02);
        wr(1, 64'h2108, 4'h5, 64'hB1, 8'h08);
      end
    join

    // Split handshake: AW accepted at edge 2, W at edge 5
    m_awready = 1'b0; m_wready = 1'b0;
    push_wr(0, 64'h3000, 4'h6, 64'h3333, 8'h33, 1'b0);
    fork
      wr(0, 64'h3000, 4'h6, 64'h3333, 8'h33);
      begin
        @(posedge aclk); #1; m_awready = 1'b1;
        @(negedge aclk);
        chk("t3_awvalid_c1", 64'(m_awvalid), 64'd1);
        chk("t3_wvalid_c1", 64'(m_wvalid), 64'd1);
        @(posedge aclk); #1; m_awready = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(negedge aclk);
          chk("t3_awvalid_dropped", 64'(m_awvalid), 64'd0);
          chk("t3_wvalid_held", 64'(m_wvalid), 64'd1);
          @(posedge aclk); #1;
        end
        m_wready = 1'b1;
        @(negedge aclk);
        chk("t3_wvalid_c4", 64'(m_wvalid), 64'd1);
        chk("t3_bready_in_addr", 64'(m_bready), 64'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t3_wvalid_done", 64'(m_wvalid), 64'd0);
        chk("t3_bready_in_resp", 64'(m_bready), 64'd1);
      end
    join
    m_awready = 1'b1;

    // Concurrent read (requester 1) and write (requester 0)
    push_wr(0, 64'h4000, 4'h7, 64'h4444, 8'hF0, 1'b0);
    push_rd(1, 64'h20, 4'h5, 64'h1234, 1'b0);
    fork
      wr(0, 64'h4000, 4'h7, 64'h4444, 8'hF0);
      rd(1, 64'h20, 4'h5);
    join

    // R back-pressure: requester 0 holds rready low for 4 cycles
    slv_rresp = 1'b1;
    s_rready[0] = 1'b0;
    push_rd(0, 64'h40, 4'h3, 64'h1254, 1'b1);
    fork
      rd(0, 64'h40, 4'h3);
      begin
        int t;
        t = 0;
        do begin @(negedge aclk); t++; end while (!m_rvalid && t < 50);
        chk("t5_rvalid_seen", 64'(m_rvalid), 64'd1);
        for (int k = 0; k < 4; k++) begin
          chk("t5_rready_low", 64'(m_rready), 64'd0);
          chk("t5_s_rvalid0", 64'(s_rvalid), 64'd1);
          if (k < 3) @(negedge aclk);
        end
        @(posedge aclk); #1; s_rready[0] = 1'b1;
        @(negedge aclk); chk("t5_rready_high", 64'(m_rready), 64'd1);
      end
    join
    slv_rresp = 1'b0;

    // Reset while requester 1 sits in the write response phase
    @(posedge aclk); #1;
    s_bready[1] = 1'b0;
    aw_q.push_back('{addr: 64'h6000, id: 4'h8, prot: 3'd3});
    w_q.push_back('{data: 64'h6666, strb: 8'hFF});
    s_awaddr[1] = 64'h6000; s_awid[1] = 4'h8; s_awprot[1] = 3'd3;
    s_wdata[1] = 64'h6666; s_wstrb[1] = 8'hFF;
    s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b0;
    @(negedge aclk); chk("t6_bvalid_pending", 64'(s_bvalid), 64'd2);
    @(posedge aclk); #1; arst = 1'b1;
    @(posedge aclk); #1; arst = 1'b0;
    @(negedge aclk);
    chk("t6_rst_s_outputs",
        64'({s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp}), 64'd0);
    chk("t6_rst_m_outputs", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
    @(posedge aclk); #1;
    s_bready[1] = 1'b1;
    push_wr(0, 64'h7000, 4'h9, 64'h7777, 8'h11, 1'b0);
    push_wr(1, 64'h7100, 4'hA, 64'h7171, 8'h22, 1'b0);
    fork
      wr(0, 64'h7000, 4'h9, 64'h7777, 8'h11);
      wr(1, 64'h7100, 4'hA, 64'h7171, 8'h22);
    join

    repeat (5) @(negedge aclk);
    chk("aw_q_drained", 64'(aw_q.size()), 64'd0);
    chk("w_q_drained", 64'(w_q.size()), 64'd0);
    chk("b_q_drained", 64'(b_q.size()), 64'd0);
    chk("ar_q_drained", 64'(ar_q.size()), 64'd0);
    chk("r_q_drained", 64'(r_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

N-to-1 AXI-lite arbiter that shares one downstream AXI-lite slave port between N upstream requesters (drivers/BFMs or RTL masters). The write channel group (AW/W/B) and the read channel group (AR/R) are arbitrated independently with round-robin fairness. Each group allows one outstanding transaction. The arbiter sits between the requester-side `axi_lite_if` instances and the single target-side `axi_lite_if`.

## Interface
- `N`, default 2: number of requesters, legal range 2..4.
- `aclk  in  1`: clock; all logic on posedge.
- `arst  in  1`: reset, synchronous, active-high.
- `s_awaddr/s_awid/s_awprot/s_awvalid  in  N×64/N×4/N×3/N×1`: requester AW channels.
- `s_wdata/s_wstrb/s_wvalid  in  N×64/N×8/N×1`: requester W channels.
- `s_bready/s_arvalid/s_rready  in  N×1`: requester B ready, AR valid, and R ready.
- `s_araddr/s_arid/s_arprot  in  N×64/N×4/N×3`: requester AR payload.
- `s_awready/s_wready/s_bvalid/s_bresp  out  N×1`: per-requester write handshakes and response.
- `s_arready/s_rvalid/s_rresp  out  N×1`: per-requester read handshakes and response.
- `s_rdata/s_rid  out  N×64/N×4`: per-requester read data and ID.
- `m_awaddr/m_awid/m_awprot/m_awvalid  out  64/4/3/1`: downstream AW.
- `m_wdata/m_wstrb/m_wvalid  out  64/8/1`: downstream W.
- `m_bready/m_arvalid/m_rready  out  1`: downstream B ready, AR valid, and R ready.
- `m_araddr/m_arid/m_arprot  out  64/4/3`: downstream AR payload.
- `m_awready/m_wready/m_bvalid/m_bresp  in  1`: downstream write handshakes and response.
- `m_arready/m_rvalid/m_rresp/m_rid/m_rdata  in  1/1/1/4/64`: downstream read return.

## Operation
- The write FSM has states W_IDLE, W_ADDR, and W_RESP.
  - W_IDLE: the request vector is s_awvalid. If it is nonzero, register `wgnt` = the first set index searching from `wlast+1` mod N. Go to W_ADDR.
  - W_ADDR: requester `wgnt`'s AW and W are routed downstream, with ready routed back.
    - Flags `aw_done` and `w_done` set on the respective downstream handshake.
    - m_awvalid is forced to 0 once `aw_done` is set; m_wvalid is forced to 0 once `w_done` is set.
    - When both are done (the same-cycle case counts), go to W_RESP.
  - W_RESP: m_bready = s_bready[wgnt]; s_bvalid[wgnt] = m_bvalid; s_bresp[wgnt] = m_bresp.
    - On the B handshake: `wlast` ← `wgnt`, clear the flags, go to W_IDLE.
- The read FSM has states R_IDLE, R_ADDR, and R_DATA. It is identical in structure to the write FSM.
  - Request vector is s_arvalid; it uses `rgnt` and `rlast`.
  - R_ADDR leaves on the AR handshake.
  - R_DATA routes R (rdata, rid, rresp, rvalid) to requester `rgnt`. It returns to R_IDLE on the R handshake and updates `rlast`.
- Non-granted requesters see all ready/valid outputs at 0. s_rdata/s_rid are broadcast to all requesters; only the qualifying valid is per-requester.
- Payload passes unmodified: ID, prot, strb, and addr are not remapped. Response routing relies solely on the locked grant.
- The grant is held until the response completes. A requester dropping valid mid-W_ADDR violates protocol, and behaviour in that case is undefined.
- The read and write groups may be granted to different requesters or the same requester concurrently.

## Timing
- Reset: state is IDLE, flags are 0, `wlast`/`rlast` = N-1 (so requester 0 wins first). Every s_* ready/valid output and every m_* valid/ready output is 0.
- Arbitration costs 1 cycle. A request sampled in IDLE at edge k appears as m_awvalid/m_arvalid from cycle k+1.
- Routing in ADDR, RESP, and DATA is combinational: there is zero added latency per handshake beyond arbitration.
- Minimum back-to-back write spacing: IDLE → ADDR → RESP → IDLE is 3 cycles when the slave responds immediately. Reads have the same spacing.
- A downstream m_bvalid/m_rvalid outside RESP/DATA is ignored (m_bready/m_rready are 0).
- Reset mid-transaction: the transaction is abandoned. Outputs are 0 in the cycle after the reset edge, and no response is delivered.
- Simultaneous requests are resolved purely by the round-robin pointer. A single requester can win consecutively if no other requester is requesting.

## Test plan
- Single write, requester 0: awaddr=0x1000, wdata=0xDEADBEEF_00000001, wstrb=0xFF; slave awready=wready=1, bvalid the next cycle, bresp=0 -> m_awvalid rises 1 cycle after s_awvalid; s_bvalid[0] pulses; s_bvalid[1] stays 0.
- Contention: both requesters assert AW+W at cycle 0, continuously -> grant order 0,1,0,1 over 4 writes; never two consecutive grants to the same requester.
- Split handshake: slave asserts awready at cycle 2 and wready at cycle 5 -> m_awvalid drops after cycle 2, m_wvalid is held until cycle 5, then W_RESP.
- Concurrent read/write: requester 1 reads araddr=0x20 while requester 0 writes -> rdata=0x1234 with rid=s_arid[1] reaches s_rvalid[1] only; the write completes independently.
- Back-pressure: s_rready[0]=0 for 4 cycles with m_rvalid=1 -> m_rready=0 for those cycles; data is transferred on the cycle s_rready rises.
- Reset in W_RESP -> all outputs 0 the next cycle; the next request is granted to requester 0.
